bin_share_arbiter: RTL and testbench

Round-robin scheduler that shares one `unary_binary_code` binarizer (TRU/unary) among `NUM_REQ` syntax-element requesters in the HEVC binarization path. It accepts one request at a time and latches that requester's operands. It then issues a single-cycle start to the binarizer, waits for its done (bounded by a watchdog), and returns the bin string and length tagged with the requester id over a valid/ready response port.

---
 rtl/bin_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_bin_share_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_share_arbiter.sv
// Round-robin front end that time-shares one TRU/unary binarizer among NUM_REQ
// syntax-element requesters and returns id-tagged bin strings over valid/ready.
module bin_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BIN_WIDTH      = 16,
  parameter int VALUE_WIDTH    = 8,
  parameter int CMAX_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] value_i,
  input  logic [NUM_REQ*CMAX_WIDTH-1:0]  cmax_i,
  input  logic [NUM_REQ-1:0]            sel_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          bz_start_o,
  output logic [VALUE_WIDTH-1:0]        bz_value_o,
  output logic [CMAX_WIDTH-1:0]         bz_cmax_o,
  output logic                          bz_sel_o,
  input  logic [BIN_WIDTH-1:0]          bz_bin_i,
  input  logic                          bz_done_i,
  input  logic [BIN_WIDTH-1:0]          bz_len_i,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [BIN_WIDTH-1:0]          rsp_bin_o,
  output logic [BIN_WIDTH-1:0]          rsp_len_o,
  output logic                          rsp_err_o,
  input  logic                          rsp_ready_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        last_q, last_d, cur_q, cur_d, rid_q, rid_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [CMAX_WIDTH-1:0]  cmax_q, cmax_d;
  logic                   sel_q, sel_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d, len_q, len_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_REQ-1:0][VALUE_WIDTH-1:0] val_a;
  logic [NUM_REQ-1:0][CMAX_WIDTH-1:0]  cmax_a;
  assign val_a  = value_i;
  assign cmax_a = cmax_i;

  // Search begins just after the last served requester, ascending with wrap.
  logic            win_vld;
  logic [ID_W-1:0] win_id;
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!win_vld && req_i[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    rid_d   = rid_q;
    gnt_d   = '0;
    value_d = value_q;
    cmax_d  = cmax_q;
    sel_d   = sel_q;
    bin_d   = bin_q;
    len_d   = len_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (win_vld) begin
        gnt_d   = NUM_REQ'(1) << win_id;
        cur_d   = win_id;
        value_d = val_a[win_id];
        cmax_d  = cmax_a[win_id];
        sel_d   = sel_i[win_id];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the final watchdog cycle still wins over the timeout.
        if (bz_done_i) begin
          bin_d   = bz_bin_i;
          len_d   = bz_len_i;
          err_d   = 1'b0;
          rid_d   = cur_q;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bin_d   = '0;
          len_d   = '0;
          err_d   = 1'b1;
          rid_d   = cur_q;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: if (rsp_ready_i) begin
        last_d  = cur_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      cur_q   <= '0;
      rid_q   <= '0;
      gnt_q   <= '0;
      value_q <= '0;
      cmax_q  <= '0;
      sel_q   <= 1'b0;
      bin_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      rid_q   <= rid_d;
      gnt_q   <= gnt_d;
      value_q <= value_d;
      cmax_q  <= cmax_d;
      sel_q   <= sel_d;
      bin_q   <= bin_d;
      len_q   <= len_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign bz_start_o  = (state_q == S_ISSUE);
  assign bz_value_o  = value_q;
  assign bz_cmax_o   = cmax_q;
  assign bz_sel_o    = sel_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_id_o    = rid_q;
  assign rsp_bin_o   = bin_q;
  assign rsp_len_o   = len_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_bin_share_arbiter.sv
// Bench for bin_share_arbiter: transaction-level reference model plus a TRU/unary
// binarizer stand-in; directed scenarios followed by a randomized run.
module tb_bin_share_arbiter;
  localparam int N = 4, BW = 16, VW = 8, CW = 3, TO = 64, IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_i;
  logic [N*VW-1:0] value_i;
  logic [N*CW-1:0] cmax_i;
  logic [N-1:0]    sel_i;
  logic [N-1:0]    gnt_o;
  logic            bz_start_o;
  logic [VW-1:0]   bz_value_o;
  logic [CW-1:0]   bz_cmax_o;
  logic            bz_sel_o;
  logic [BW-1:0]   bz_bin_i;
  logic            bz_done_i;
  logic [BW-1:0]   bz_len_i;
  logic            rsp_valid_o;
  logic [IW-1:0]   rsp_id_o;
  logic [BW-1:0]   rsp_bin_o;
  logic [BW-1:0]   rsp_len_o;
  logic            rsp_err_o;
  logic            rsp_ready_i;

  always #5 clk = ~clk;

  bin_share_arbiter #(.NUM_REQ(N), .BIN_WIDTH(BW), .VALUE_WIDTH(VW), .CMAX_WIDTH(CW),
                      .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .value_i(value_i), .cmax_i(cmax_i),
    .sel_i(sel_i), .gnt_o(gnt_o), .bz_start_o(bz_start_o), .bz_value_o(bz_value_o),
    .bz_cmax_o(bz_cmax_o), .bz_sel_o(bz_sel_o), .bz_bin_i(bz_bin_i),
    .bz_done_i(bz_done_i), .bz_len_i(bz_len_i), .rsp_valid_o(rsp_valid_o),
    .rsp_id_o(rsp_id_o), .rsp_bin_o(rsp_bin_o), .rsp_len_o(rsp_len_o),
    .rsp_err_o(rsp_err_o), .rsp_ready_i(rsp_ready_i));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: cycle budget expired @%0t", name, $time);
  endtask

  // TRU code: value ones then a terminating zero, the zero dropped at value==cMax.
  function automatic void bin_code(input int v, input int c, input bit s,
                                   output logic [BW-1:0] b, output logic [BW-1:0] l);
    int ones, term;
    if (s || v < c) begin ones = v; term = 1; end
    else begin ones = c; term = 0; end
    b = BW'(((1 << ones) - 1) << term);
    l = BW'(ones + term);
  endfunction

  // Binarizer stand-in: done lat_cfg cycles after start (0 = never answers).
  int            bz_cd = -1;
  int            lat_cfg = 3;
  bit            force_done = 1'b0;
  logic [BW-1:0] pend_bin = '0, pend_len = '0;

  task automatic bz_drive();
    bz_done_i = 1'b0;
    bz_bin_i  = BW'($urandom);
    bz_len_i  = BW'($urandom);
    if (bz_cd > 0) begin
      bz_cd--;
      if (bz_cd == 0) begin
        bz_done_i = 1'b1; bz_bin_i = pend_bin; bz_len_i = pend_len; bz_cd = -1;
      end
    end
    if (bz_start_o === 1'b1 && lat_cfg > 0) begin
      bz_cd = lat_cfg;
      bin_code(int'(bz_value_o), int'(bz_cmax_o), bz_sel_o, pend_bin, pend_len);
    end
    if (force_done) begin
      bz_done_i = 1'b1; bz_bin_i = pend_bin; bz_len_i = pend_len;
    end
    if (!rst_n) bz_cd = -1;
  endtask

  // Reference model: one transaction in flight, tracked by its age since grant.
  bit            m_busy = 0, m_resp = 0, m_sel = 0, m_err = 0;
  int            m_age = 0, m_owner = 0, m_last = N - 1, m_rid = 0;
  logic [VW-1:0] m_val = '0;
  logic [CW-1:0] m_cmax = '0;
  logic [BW-1:0] m_bin = '0, m_len = '0;

  task automatic model_step();
    if (!rst_n) begin
      m_busy = 0; m_resp = 0; m_age = 0; m_last = N - 1; m_val = '0; m_cmax = '0;
      m_sel = 0; m_rid = 0; m_bin = '0; m_len = '0; m_err = 0;
    end else if (!m_busy) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_last + i) % N;
        if (!m_busy && req_i[k]) begin
          m_busy = 1; m_age = 1; m_owner = k;
          m_val = value_i[k*VW +: VW]; m_cmax = cmax_i[k*CW +: CW]; m_sel = sel_i[k];
        end
      end
    end else if (m_resp) begin
      if (rsp_ready_i) begin m_busy = 0; m_resp = 0; m_last = m_owner; end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (bz_done_i) begin
      m_resp = 1; m_rid = m_owner; m_bin = bz_bin_i; m_len = bz_len_i; m_err = 0;
    end else if (m_age - 1 == TO) begin
      m_resp = 1; m_rid = m_owner; m_bin = '0; m_len = '0; m_err = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_all();
    bit issue;
    issue = m_busy && !m_resp && m_age == 1;
    chk("gnt", gnt_o, issue ? (32'd1 << m_owner) : 32'd0);
    chk("start", bz_start_o, issue);
    chk("valid", rsp_valid_o, m_resp);
    chk("bz_value", bz_value_o, m_val);
    chk("bz_cmax", bz_cmax_o, m_cmax);
    chk("bz_sel", bz_sel_o, m_sel);
    if (m_resp) begin
      chk("rsp_id", rsp_id_o, m_rid);
      chk("rsp_bin", rsp_bin_o, m_bin);
      chk("rsp_len", rsp_len_o, m_len);
      chk("rsp_err", rsp_err_o, m_err);
    end
  endtask

  task automatic tick();
    bz_drive();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // One cycle; a requester drops its request as soon as it sees its grant.
  task automatic step();
    tick();
    req_i = req_i & ~gnt_o;
  endtask

  task automatic set_ops(input int k, input int v, input int c, input bit s);
    value_i[k*VW +: VW] = VW'(v);
    cmax_i[k*CW +: CW]  = CW'(c);
    sel_i[k]            = s;
  endtask

  task automatic wait_gnt(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (gnt_o != '0) ok = 1;
    end
    if (!ok) bound_expired(name);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (rsp_valid_o) ok = 1;
    end
    if (!ok) bound_expired(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    int cnt, gid;
    int gq[$];
    bit [N-1:0] pend;

    rst_n = 1'b0; req_i = '0; value_i = '0; cmax_i = '0; sel_i = '0;
    rsp_ready_i = 1'b1; bz_done_i = 1'b0; bz_bin_i = '0; bz_len_i = '0;
    @(negedge clk);
    do_reset();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_start", bz_start_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_bin", rsp_bin_o, 0);
    chk("rst_value", bz_value_o, 0);

    // Single request from requester 2.
    lat_cfg = 3;
    set_ops(2, 2, 3, 0);
    req_i = 4'b0100;
    wait_gnt("t1_gnt_wait", ok);
    chk("t1_gnt", gnt_o, 4'b0100);
    chk("t1_start", bz_start_o, 1);
    wait_valid("t1_valid_wait", ok);
    chk("t1_id", rsp_id_o, 2);
    chk("t1_bin", rsp_bin_o, 16'h0006);
    chk("t1_len", rsp_len_o, 3);
    chk("t1_err", rsp_err_o, 0);
    step();
    chk("t1_valid_drop", rsp_valid_o, 0);

    // All four requesting from reset: strict round-robin order.
    do_reset();
    for (int k = 0; k < N; k++) set_ops(k, k + 1, k + 2, k[0]);
    lat_cfg = 2;
    req_i = 4'hF;
    for (int i = 0; i < 300 && gq.size() < 5; i++) begin
      tick();
      if (gnt_o != '0) begin
        gid = 0;
        for (int k = 0; k < N; k++) if (gnt_o[k]) gid = k;
        gq.push_back(gid);
        chk("t2_op_value", bz_value_o, gid + 1);
        chk("t2_op_cmax", bz_cmax_o, gid + 2);
        chk("t2_op_sel", bz_sel_o, gid % 2);
      end
      if (rsp_valid_o && gq.size() > 0) chk("t2_rsp_id", rsp_id_o, gq[gq.size()-1]);
      req_i = 4'hF & ~gnt_o;
    end
    if (gq.size() < 5) bound_expired("t2_grants");
    else for (int i = 0; i < 5; i++) chk("t2_order", gq[i], i % N);
    req_i = '0;
    repeat (20) step();

    // Backpressure: ten stalled cycles, nothing new issued.
    rsp_ready_i = 1'b0;
    set_ops(0, 3, 5, 0);
    set_ops(1, 4, 2, 1);
    req_i = 4'b0011;
    wait_valid("t3_valid_wait", ok);
    cnt = 0;
    repeat (10) begin
      step();
      if (gnt_o != '0 || bz_start_o) cnt++;
    end
    chk("t3_no_issue", cnt, 0);
    chk("t3_valid_held", rsp_valid_o, 1);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("t3_one_rsp", rsp_valid_o, 0);
    rsp_ready_i = 1'b1;
    repeat (20) step();

    // Watchdog: binarizer never answers.
    lat_cfg = 0;
    set_ops(2, 5, 7, 0);
    req_i = 4'b0100;
    wait_gnt("t4_gnt_wait", ok);
    cnt = 0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      cnt++;
      if (rsp_valid_o) ok = 1;
    end
    if (!ok) bound_expired("t4_timeout_wait");
    // First tick after the grant is the WAIT-entry edge, then 64 WAIT cycles.
    chk("t4_latency", cnt, TO + 1);
    chk("t4_err", rsp_err_o, 1);
    chk("t4_bin", rsp_bin_o, 0);
    chk("t4_len", rsp_len_o, 0);
    repeat (5) step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    cnt = 0;
    repeat (20) begin
      step();
      if (rsp_valid_o) cnt++;
    end
    chk("t4_late_done", cnt, 0);

    // Reset in the middle of WAIT.
    set_ops(0, 1, 1, 0);
    req_i = 4'b0001;
    wait_gnt("t5_gnt_wait", ok);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_gnt", gnt_o, 0);
    chk("t5_start", bz_start_o, 0);
    chk("t5_valid", rsp_valid_o, 0);
    chk("t5_value", bz_value_o, 0);
    chk("t5_id", rsp_id_o, 0);
    chk("t5_err", rsp_err_o, 0);
    lat_cfg = 2;
    req_i = 4'b1010;
    wait_gnt("t5_gnt2_wait", ok);
    chk("t5_first_gnt", gnt_o, 4'b0010);
    repeat (30) step();

    // Extreme operands in unary mode.
    lat_cfg = 3;
    set_ops(1, 7, 3, 1);
    req_i = 4'b0010;
    wait_gnt("t6_gnt_wait", ok);
    chk("t6_value", bz_value_o, 7);
    chk("t6_cmax", bz_cmax_o, 3);
    chk("t6_sel", bz_sel_o, 1);
    wait_valid("t6_valid_wait", ok);
    chk("t6_id", rsp_id_o, 1);
    chk("t6_bin", rsp_bin_o, 16'h00FE);
    chk("t6_len", rsp_len_o, 8);
    step();

    // Randomized traffic against the model.
    pend = '0;
    repeat (3000) begin
      rst_n       = ($urandom_range(0, 999) != 0);
      rsp_ready_i = ($urandom_range(0, 9) < 7);
      lat_cfg     = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
      force_done  = ($urandom_range(0, 31) == 0);
      tick();
      for (int k = 0; k < N; k++) begin
        if (pend[k] && gnt_o[k]) pend[k] = 1'b0;
        else if (!pend[k] && $urandom_range(0, 7) == 0) begin
          pend[k] = 1'b1;
          set_ops(k, int'($urandom_range(0, 14)), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)));
        end
      end
      req_i = pend;
    end
    force_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
